// File: rtl/muldiv_unit_pkg.sv
// Shared CPU package for the HI/LO multiply/divide unit.
// Holds the R-type funct codes, the FSM state encoding and the opcode decoder.
package muldiv_unit_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Counter value loaded at start; the step taken at zero is the 32nd.
    localparam logic [4:0] LAST_BIT_COUNT = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic isMul;
        logic isDiv;
        logic isSigned;
    } op_t;

    // Signed opcodes only decode when the signed build enables them;
    // otherwise they fall through as unsupported and are ignored.
    function automatic op_t decodeOp(input logic [5:0] funct, input logic signedEn);
        op_t op;
        op = '0;
        case (funct)
            FUNCT_MULTU: op.isMul = 1'b1;
            FUNCT_DIVU:  op.isDiv = 1'b1;
            FUNCT_MULT: begin
                op.isMul    = signedEn;
                op.isSigned = signedEn;
            end
            FUNCT_DIV: begin
                op.isDiv    = signedEn;
                op.isSigned = signedEn;
            end
            default: op = '0;
        endcase
        return op;
    endfunction

    // Absolute value of a two's-complement operand when the op is signed.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic isSigned);
        return (isSigned && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage bus between the pipeline and the multiply/divide unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_unit_if;

    logic        validIn;
    logic [5:0]  funct;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mfData;

    modport master (
        output validIn, funct, srcA, srcB, flush,
        input  busy, done, hi, lo, mfData
    );

    modport slave (
        input  validIn, funct, srcA, srcB, flush,
        output busy, done, hi, lo, mfData
    );

endinterface

// File: rtl/muldiv_core.sv
// Iterative datapath: one bit per cycle of shift-add multiply or restoring
// divide on unsigned magnitudes, plus the 5-bit step counter.
// The accumulator holds {upper, lower}: product halves for multiply,
// {remainder, quotient/dividend} for divide.
module muldiv_core
    import muldiv_unit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_isDiv,
    input  logic        i_step,
    input  logic [31:0] i_opA,
    input  logic [31:0] i_opB,
    output logic [63:0] o_accNext,
    output logic        o_lastStep
);

    logic [63:0] r_acc;
    logic [31:0] r_opB;
    logic [4:0]  r_counter;

    logic [32:0] w_mulSum;
    logic [32:0] w_divRem;
    logic [31:0] w_divDiff;
    logic        w_divFits;

    // Next accumulator value for one iteration of the selected algorithm.
    always_comb begin
        w_mulSum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opB} : 33'd0);
        w_divRem  = {r_acc[63:32], r_acc[31]};
        w_divFits = (w_divRem >= {1'b0, r_opB});
        w_divDiff = w_divRem[31:0] - r_opB;
        if (i_isDiv) begin
            o_accNext = {(w_divFits ? w_divDiff : w_divRem[31:0]), r_acc[30:0], w_divFits};
        end else begin
            o_accNext = {w_mulSum, r_acc[31:1]};
        end
    end

    assign o_lastStep = (r_counter == 5'd0);

    // Operands load on start, then the accumulator advances once per step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_opB     <= '0;
            r_counter <= '0;
        end else if (i_load) begin
            r_acc     <= {32'd0, i_opA};
            r_opB     <= i_opB;
            r_counter <= LAST_BIT_COUNT;
        end else if (i_step) begin
            r_acc     <= o_accNext;
            r_counter <= r_counter - 5'd1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the EX stage: FSM, HI/LO registers,
// busy stall request and MFHI/MFLO read mux around muldiv_core.
// Build option: define MULDIV_SIGNED_EN to also execute MULT and DIV.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    muldiv_unit_if.slave  bus
);

`ifdef MULDIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    state_t      r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_negLow;
    logic        r_negHigh;

    op_t         w_op;
    logic        w_start;
    logic        w_computing;
    logic        w_step;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [63:0] w_accNext;
    logic        w_lastStep;
    logic [63:0] w_product;
    logic [31:0] w_quotient;
    logic [31:0] w_remainder;
    logic [31:0] w_resultHi;
    logic [31:0] w_resultLo;

    // A start needs an idle unit; the reset term keeps busy low while held in reset.
    assign w_op        = decodeOp(bus.funct, SIGNED_EN);
    assign w_start     = i_rst_n & bus.validIn & (w_op.isMul | w_op.isDiv)
                         & (r_state == ST_IDLE) & ~bus.flush;
    assign w_computing = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign w_step      = w_computing & ~bus.flush;
    assign w_magA      = magnitude(bus.srcA, w_op.isSigned);
    assign w_magB      = magnitude(bus.srcB, w_op.isSigned);

    assign bus.busy = w_start | w_computing;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    muldiv_core u_core (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_start),
        .i_isDiv    (r_state == ST_DIV),
        .i_step     (w_step),
        .i_opA      (w_magA),
        .i_opB      (w_magB),
        .o_accNext  (w_accNext),
        .o_lastStep (w_lastStep)
    );

    // Restore signs on the final step's value before it is written to HI/LO.
    always_comb begin
        w_product   = r_negLow  ? (~w_accNext + 64'd1)         : w_accNext;
        w_quotient  = r_negLow  ? (~w_accNext[31:0] + 32'd1)   : w_accNext[31:0];
        w_remainder = r_negHigh ? (~w_accNext[63:32] + 32'd1)  : w_accNext[63:32];
        if (r_state == ST_DIV) begin
            w_resultHi = w_remainder;
            w_resultLo = w_quotient;
        end else begin
            w_resultHi = w_product[63:32];
            w_resultLo = w_product[31:0];
        end
    end

    // MFHI/MFLO read the architectural registers directly.
    always_comb begin
        case (bus.funct)
            FUNCT_MFHI: bus.mfData = r_hi;
            FUNCT_MFLO: bus.mfData = r_lo;
            default:    bus.mfData = 32'd0;
        endcase
    end

    // Control FSM: flush beats completion, and DONE always falls back to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_negLow  <= 1'b0;
            r_negHigh <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= w_op.isDiv ? ST_DIV : ST_MUL;
                        r_negLow  <= w_op.isSigned & (bus.srcA[31] ^ bus.srcB[31]);
                        r_negHigh <= w_op.isSigned & w_op.isDiv & bus.srcA[31];
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                    end else if (w_lastStep) begin
                        r_hi    <= w_resultHi;
                        r_lo    <= w_resultLo;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// flush / reset / configuration sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int BUDGET = 60;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs [7];

    // Reference results from the arithmetic definition of each opcode.
    function automatic void refModel(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        logic [31:0] ma, mb, q, r;
        hi = 32'd0;
        lo = 32'd0;
        case (f)
            FUNCT_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            FUNCT_DIVU: begin
                lo = (b == 0) ? 32'hFFFFFFFF : a / b;
                hi = (b == 0) ? a : a % b;
            end
            FUNCT_MULT: begin
                p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                hi = p[63:32];
                lo = p[31:0];
            end
            FUNCT_DIV: begin
                ma = a[31] ? -a : a;
                mb = b[31] ? -b : b;
                q  = (mb == 0) ? 32'hFFFFFFFF : ma / mb;
                r  = (mb == 0) ? ma : ma % mb;
                lo = (a[31] ^ b[31]) ? -q : q;
                hi = a[31] ? -r : r;
            end
            default: ;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one instruction and hold it while stalled, as the pipeline would.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output int busyCycles, output int doneCycles,
                                 output logic [31:0] hiOut, output logic [31:0] loOut);
        bit sawDone;
        busyCycles = 0;
        doneCycles = 0;
        sawDone    = 1'b0;
        hiOut      = 32'd0;
        loOut      = 32'd0;
        @(negedge clk);
        bus.validIn = 1'b1;
        bus.funct   = f;
        bus.srcA    = a;
        bus.srcB    = b;
        #1;
        if (bus.busy) busyCycles++;
        for (int i = 0; i < BUDGET && !sawDone; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                doneCycles++;
                sawDone = 1'b1;
                hiOut   = bus.hi;
                loOut   = bus.lo;
            end
        end
        @(negedge clk);
        bus.validIn = 1'b0;
        bus.funct   = 6'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busyCycles++;
            if (bus.done) doneCycles++;
        end
    endtask

    task automatic runAndCheck(input string name, input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        int bc, dc;
        logic [31:0] h, l;
        applyStimulus(f, a, b, bc, dc, h, l);
        checkOutput({name, "_hi"}, {32'd0, h}, {32'd0, expHi});
        checkOutput({name, "_lo"}, {32'd0, l}, {32'd0, expLo});
        checkOutput({name, "_busy33"}, 64'(bc), 64'd33);
        checkOutput({name, "_done1"}, 64'(dc), 64'd1);
    endtask

    // Count done pulses over a window with the instruction removed.
    task automatic countDone(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dones, busyCount, nOps;
        logic [5:0]  f;
        logic [31:0] a, b, eh, el;
        logic [5:0]  opList [4];

        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        bus.validIn = 1'b0;
        bus.funct   = 6'h00;
        bus.srcA    = 32'd0;
        bus.srcB    = 32'd0;
        bus.flush   = 1'b0;

        vecs[0] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[1] = '{FUNCT_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[2] = '{FUNCT_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[3] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[4] = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[5] = '{FUNCT_DIVU,  32'd3,        32'd10,       32'd3,        32'd0};
        vecs[6] = '{FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        // Reset state
        #2;
        checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
        checkOutput("reset_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, bus.lo}, 64'd0);
        checkOutput("reset_mf", {32'd0, bus.mfData}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
                        vecs[i].expHi, vecs[i].expLo);
        end

        // DIVU 100/7 followed by MFLO / MFHI / other funct
        runAndCheck("div100_7", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        @(negedge clk);
        bus.validIn = 1'b1;
        bus.funct   = FUNCT_MFLO;
        #1;
        checkOutput("mflo", {32'd0, bus.mfData}, 64'd14);
        bus.funct = FUNCT_MFHI;
        #1;
        checkOutput("mfhi", {32'd0, bus.mfData}, 64'd2);
        bus.funct = 6'h20;
        #1;
        checkOutput("mf_other", {32'd0, bus.mfData}, 64'd0);
        @(negedge clk);
        bus.validIn = 1'b0;
        bus.funct   = 6'h00;

        // Flush in the 10th compute cycle of MULTU 3x4
        @(negedge clk);
        bus.validIn = 1'b1;
        bus.funct   = FUNCT_MULTU;
        bus.srcA    = 32'd3;
        bus.srcB    = 32'd4;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("flush_busy_before", {63'd0, bus.busy}, 64'd1);
        bus.flush   = 1'b1;
        bus.validIn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("flush_busy_after", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        countDone(40, dones);
        checkOutput("flush_no_done", 64'(dones), 64'd0);
        checkOutput("flush_hi_kept", {32'd0, bus.hi}, 64'd2);
        checkOutput("flush_lo_kept", {32'd0, bus.lo}, 64'd14);

        // Flush concurrent with start
        @(negedge clk);
        bus.validIn = 1'b1;
        bus.funct   = FUNCT_MULTU;
        bus.srcA    = 32'd5;
        bus.srcB    = 32'd5;
        bus.flush   = 1'b1;
        #1;
        checkOutput("flushstart_busy0", {63'd0, bus.busy}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("flushstart_busy1", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        bus.validIn = 1'b0;
        bus.flush   = 1'b0;
        countDone(40, dones);
        checkOutput("flushstart_no_done", 64'(dones), 64'd0);
        checkOutput("flushstart_lo_kept", {32'd0, bus.lo}, 64'd14);

        // Reset in the middle of DIVU
        @(negedge clk);
        bus.validIn = 1'b1;
        bus.funct   = FUNCT_DIVU;
        bus.srcA    = 32'd100;
        bus.srcB    = 32'd7;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("rstmid_done", {63'd0, bus.done}, 64'd0);
        checkOutput("rstmid_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("rstmid_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        bus.validIn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        countDone(40, dones);
        checkOutput("rstmid_no_done", 64'(dones), 64'd0);
        runAndCheck("mul6_7", FUNCT_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        // Signed opcodes
`ifdef MULDIV_SIGNED_EN
        runAndCheck("div_m7_2", FUNCT_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runAndCheck("mult_m3_5", FUNCT_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        nOps = 4;
`else
        busyCount = 0;
        @(negedge clk);
        bus.validIn = 1'b1;
        bus.funct   = FUNCT_DIV;
        bus.srcA    = 32'hFFFFFFF9;
        bus.srcB    = 32'd2;
        #1;
        if (bus.busy) busyCount++;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busyCount++;
            if (bus.done) dones++;
        end
        @(negedge clk);
        bus.validIn = 1'b0;
        bus.funct   = 6'h00;
        checkOutput("unsup_div_busy", 64'(busyCount), 64'd0);
        checkOutput("unsup_div_done", 64'(dones), 64'd0);
        checkOutput("unsup_div_lo_kept", {32'd0, bus.lo}, 64'd42);
        nOps = 2;
`endif

        // Randomized operations against the reference model
        opList[0] = FUNCT_MULTU;
        opList[1] = FUNCT_DIVU;
        opList[2] = FUNCT_MULT;
        opList[3] = FUNCT_DIV;
        for (int i = 0; i < 24; i++) begin
            f = opList[$urandom_range(0, nOps - 1)];
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            refModel(f, a, b, eh, el);
            runAndCheck($sformatf("rand%0d_f%0h", i, f), f, a, b, eh, el);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: valid_in  in  1  EX-stage instruction valid, from the ID/EX control outputs.
REQ-004 SHALL provide: funct  in  6  R-type function field, from the ID/EX register.
REQ-005 SHALL provide: src_a, src_b  in  32 each  forwarded rs/rt operands.
REQ-006 SHALL provide: flush  in  1  synchronous abort of the in-flight operation.
REQ-007 SHALL provide: busy  out  1  stall request to PC, IF/ID and ID/EX.
REQ-008 SHALL provide: done  out  1  one-cycle completion pulse.
REQ-009 SHALL provide: hi, lo  out  32 each  architectural HI/LO registers.
REQ-010 SHALL provide: mf_data  out  32  MFHI/MFLO result to the EX result mux.

Function
REQ-011 SHALL decode funct: MULTU=6'h19, DIVU=6'h1B, MFHI=6'h10, MFLO=6'h12; all other codes are ignored.
REQ-012 SHALL use FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL define start = valid_in & (MULTU|DIVU) & state==IDLE & !flush.
- On start: latch operands, load 5-bit counter with 31, go to MUL or DIV.
REQ-014 SHALL retire one bit per cycle in MUL/DIV using shift-add multiply or restoring divide, decrementing the counter each cycle.
- At counter==0: write hi/lo, go to DONE.
- Exactly 32 compute cycles.
REQ-015 SHALL write MULTU as {hi,lo} = 64-bit unsigned product.
REQ-016 SHALL write DIVU as lo = quotient, hi = remainder.
REQ-017 SHALL, for divide-by-zero, complete in the normal 32 cycles with lo=32'hFFFFFFFF and hi=src_a, with no exception.
REQ-018 SHALL drive busy combinationally = start | state∈{MUL,DIV}.
- Total busy duration: 33 cycles.
- busy is low in DONE, so the stalled instruction advances at the end of DONE.
REQ-019 SHALL assert done only in DONE; DONE always returns to IDLE on the next cycle.
REQ-020 SHALL NOT restart from the same held instruction, because start requires IDLE.
REQ-021 SHALL drive mf_data combinationally: hi for MFHI, lo for MFLO, 0 otherwise.
- hi/lo already hold the new results during DONE.
REQ-022 SHALL, on flush in MUL/DIV/DONE, return to IDLE next cycle with hi/lo unchanged (unless already written) and no done pulse.
- flush concurrent with start: flush wins, no operation begins.
REQ-023 SHALL ignore valid_in with an unsupported funct in any state.

Reset
REQ-024 SHALL, on rst low, asynchronously force state=IDLE, counter=0, hi=lo=0, operand/partial registers=0.
- busy=0, done=0; mf_data=0 until a move instruction is presented.
REQ-025 SHALL abort any in-flight operation on reset mid-operation, with no done pulse; the operation resumes only by a new start after release.

Configuration
REQ-026 SHALL support macro MULDIV_SIGNED_EN.
- Defined: additionally decode MULT=6'h18 and DIV=6'h1A.
- Signed operation: operate on magnitudes, then negate the product, quotient when signs differ, and remainder to the dividend's sign.
- Same 33-cycle busy.
REQ-027 SHALL, without MULDIV_SIGNED_EN, treat 6'h18/6'h1A as unsupported (REQ-023).

Structure
REQ-028 SHALL place funct code constants and the FSM state encoding in the shared CPU package.
REQ-029 SHALL keep the datapath in one natural sub-module, muldiv_core (iteration step + counter); the FSM and HI/LO stay in muldiv_unit.

Verification
REQ-030 SHALL cover MULTU 32'hFFFFFFFF × 32'h2 -> busy 33 cycles, then hi=1, lo=32'hFFFFFFFE, one done pulse.
REQ-031 SHALL cover DIVU 100 ÷ 7 -> lo=14, hi=2; MFLO next cycle -> mf_data=14.
REQ-032 SHALL cover DIVU 5 ÷ 0 -> lo=32'hFFFFFFFF, hi=5 after 32 compute cycles.
REQ-033 SHALL cover flush at compute cycle 10 of MULTU 3×4 -> IDLE next cycle, hi/lo keep prior values, no done pulse.
REQ-034 SHALL cover rst low mid-DIVU -> busy=0 immediately, hi=lo=0; then a fresh MULTU 6×7 -> lo=42.
REQ-035 SHALL cover, with MULDIV_SIGNED_EN, DIV -7 ÷ 2 -> lo=-3, hi=-1; without it, the same funct -> busy never asserts.
